// File: rtl/call_req_filter.sv
// Button front end: sync, debounce and edge-detect each floor button into single-cycle floor_req pulses plus pending-call lamps.
// Latency: 2+DEB_CYCLES+1 clocks from a held button to its pulse. Optional CALL_REISSUE_EN periodically re-pulses lit lamps.
module call_req_filter #(
  parameter int FLOORS         = 5,
  parameter int POS_W          = 3,
  parameter int DEB_CYCLES     = 4,
  parameter int REISSUE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] btn_raw,
  input  logic [POS_W-1:0]  floor_pos,
  input  logic              door_open,
  output logic [FLOORS-1:0] floor_req,
  output logic [FLOORS-1:0] req_lamp
);

  localparam int CNT_W = 8;

  logic [FLOORS-1:0] sync1;
  logic [FLOORS-1:0] sync2;
  logic [FLOORS-1:0] stable;
  logic [FLOORS-1:0] stable_q;
  logic [CNT_W-1:0]  deb_cnt [FLOORS];

  logic [FLOORS-1:0] clr_mask;
  logic [FLOORS-1:0] new_req;
  logic [FLOORS-1:0] reissue_mask;

  // Out-of-range floor_pos never matches any index, so it clears nothing.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < FLOORS; i++) begin
      clr_mask[i] = door_open && (int'(floor_pos) == i);
    end
    new_req = stable & ~stable_q & ~req_lamp & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < FLOORS; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < FLOORS; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef CALL_REISSUE_EN
  localparam int RW = (REISSUE_CYCLES > 2) ? $clog2(REISSUE_CYCLES) : 1;

  logic [RW-1:0] reissue_cnt;
  logic          reissue_hit;

  assign reissue_hit  = (req_lamp != '0) && (reissue_cnt == RW'(REISSUE_CYCLES - 1));
  assign reissue_mask = reissue_hit ? (req_lamp & ~clr_mask) : '0;

  always_ff @(posedge clk) begin
    if (reset || (req_lamp == '0) || reissue_hit) begin
      reissue_cnt <= '0;
    end else begin
      reissue_cnt <= reissue_cnt + 1'b1;
    end
  end
`else
  assign reissue_mask = '0;
`endif

  // Clear has priority over a set landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      floor_req <= '0;
      req_lamp  <= '0;
    end else begin
      floor_req <= new_req | reissue_mask;
      req_lamp  <= (req_lamp | new_req) & ~clr_mask;
    end
  end

endmodule

// File: tb/tb_call_req_filter.sv
// Directed bench for call_req_filter; the CALL_REISSUE_EN build adds re-issue cadence expectations.
module tb_call_req_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_raw;
  logic [2:0] floor_pos;
  logic       door_open;
  logic [4:0] floor_req;
  logic [4:0] req_lamp;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses;

  call_req_filter dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .floor_pos (floor_pos),
    .door_open (door_open),
    .floor_req (floor_req),
    .req_lamp  (req_lamp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lamp(input int f);
    floor_pos = 3'(f);
    door_open = 1'b1;
    step();
    door_open = 1'b0;
    floor_pos = 3'd7;
  endtask

  initial begin
    reset     = 1'b1;
    btn_raw   = '0;
    floor_pos = 3'd7;
    door_open = 1'b0;
    repeat (3) step();
    chk("rst_req", 32'(floor_req), 32'h0);
    chk("rst_lamp", 32'(req_lamp), 32'h0);

    // Held press on floor 3 from reset release: pulse on edge 7 only.
    reset   = 1'b0;
    btn_raw = 5'b01000;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("t1_req_e%0d", k), 32'(floor_req), (k == 7) ? 32'h08 : 32'h0);
      if (k >= 6) chk($sformatf("t1_lamp3_e%0d", k), 32'(req_lamp[3]), (k >= 7) ? 32'h1 : 32'h0);
    end

    // Release leaves the lamp alone.
    btn_raw = '0;
    repeat (12) step();
    chk("release_lamp", 32'(req_lamp), 32'h08);

    // Three-cycle glitch on floor 1 is filtered.
    pulses  = 0;
    btn_raw = 5'b00010;
    repeat (3) step();
    btn_raw = '0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (floor_req[1] || req_lamp[1]) pulses++;
    end
    chk("glitch_f1", 32'(pulses), 32'h0);

    // Out-of-range floor_pos clears nothing; floor 3 with door open clears lamp 3.
    floor_pos = 3'd7;
    door_open = 1'b1;
    step();
    chk("oor_noclear", 32'(req_lamp), 32'h08);
    floor_pos = 3'd3;
    step();
    chk("door_clear3", 32'(req_lamp), 32'h0);
    door_open = 1'b0;
    floor_pos = 3'd7;

    // Spam floor 4: three 10-high/10-low presses.
    pulses = 0;
    for (int r = 0; r < 3; r++) begin
      btn_raw = 5'b10000;
      repeat (10) begin step(); if (floor_req[4]) pulses++; end
      btn_raw = '0;
      repeat (10) begin step(); if (floor_req[4]) pulses++; end
    end
    repeat (10) begin step(); if (floor_req[4]) pulses++; end
`ifdef CALL_REISSUE_EN
    chk("spam_f4", 32'(pulses), 32'd4);
`else
    chk("spam_f4", 32'(pulses), 32'd1);
`endif
    clear_lamp(4);
    chk("spam_clear", 32'(req_lamp), 32'h0);

    // Press at the floor where the door is open: no lamp, no pulse.
    pulses    = 0;
    floor_pos = 3'd0;
    door_open = 1'b1;
    btn_raw   = 5'b00001;
    repeat (12) begin step(); if (floor_req[0] || req_lamp[0]) pulses++; end
    btn_raw = '0;
    repeat (8) begin step(); if (floor_req[0] || req_lamp[0]) pulses++; end
    door_open = 1'b0;
    floor_pos = 3'd7;
    chk("door_press_f0", 32'(pulses), 32'h0);

    // Simultaneous press on floors 1 and 4.
    btn_raw = 5'b10010;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("simul_req_e%0d", k), 32'(floor_req), (k == 7) ? 32'h12 : 32'h0);
    end
    chk("simul_lamp", 32'(req_lamp), 32'h12);
    btn_raw = '0;
    repeat (8) step();
    clear_lamp(1);
    clear_lamp(4);
    chk("simul_clear", 32'(req_lamp), 32'h0);

    // Reset mid-debounce discards progress; held button pulses 7 edges after release.
    btn_raw = 5'b00100;
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();
    chk("midrst_req", 32'(floor_req), 32'h0);
    chk("midrst_lamp", 32'(req_lamp), 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("rst2_req_e%0d", k), 32'(floor_req), (k == 7) ? 32'h04 : 32'h0);
    end

    // Lamp 2 stays set: re-issue every 16 cycles only in the CALL_REISSUE_EN build.
    for (int k = 9; k <= 40; k++) begin
      step();
`ifdef CALL_REISSUE_EN
      chk($sformatf("reissue_e%0d", k), 32'(floor_req), (((k - 7) % 16) == 0) ? 32'h04 : 32'h0);
`else
      chk($sformatf("noreissue_e%0d", k), 32'(floor_req), 32'h0);
`endif
    end
    clear_lamp(2);
    pulses = 0;
    repeat (40) begin step(); if (floor_req != '0) pulses++; end
    chk("after_clear_quiet", 32'(pulses), 32'h0);
    chk("final_lamp", 32'(req_lamp), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/call_req_filter.md
CALL_REQ_FILTER -- requirements
Module: call_req_filter

Interface
REQ-001 The parameter FLOORS SHALL default to 5 and set the number of floors.
REQ-002 The parameter POS_W SHALL default to 3 and set the floor index width.
REQ-003 The parameter DEB_CYCLES SHALL default to 4 and set the debounce length in clocks (legal range 2..255).
REQ-004 The parameter REISSUE_CYCLES SHALL default to 16 and set the re-issue interval in clocks; it is used only when CALL_REISSUE_EN is defined.
REQ-005 clk SHALL be an input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-007 btn_raw SHALL be an input, FLOORS bits: asynchronous, bouncy car and hall buttons, one bit per floor.
REQ-008 floor_pos SHALL be an input, POS_W bits: the current car floor, fed back from the elevator core.
REQ-009 door_open SHALL be an input, 1 bit: door-open status, fed back from the elevator core.
REQ-010 floor_req SHALL be an output, FLOORS bits: single-cycle request pulses driving the elevator core floor_req input.
REQ-011 req_lamp SHALL be an output, FLOORS bits: the pending-call indicator for each floor.

Function
REQ-012 Each btn_raw bit SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Per floor, a debounce counter SHALL reset to 0 when the synchronized bit equals the stable bit.
REQ-014 When the synchronized bit differs from the stable bit, the counter SHALL increment; at DEB_CYCLES-1 with the bits still differing, stable SHALL take the synchronized value and the counter SHALL return to 0.
REQ-015 A btn_raw level held constant from edge 0 SHALL update the stable bit at edge 2+DEB_CYCLES (edge 6 by default).
REQ-016 Pulses and gaps shorter than DEB_CYCLES clocks after synchronization SHALL be ignored.
REQ-017 A stable 0->1 transition on floor i SHALL set req_lamp[i] and assert floor_req[i] for exactly one cycle at the next edge (edge 2+DEB_CYCLES+1, i.e. 7 by default), provided req_lamp[i]=0 and not (door_open=1 and floor_pos=i).
REQ-018 A press on a floor whose lamp is already set SHALL produce no floor_req pulse (spam suppression).
REQ-019 A press on floor i while door_open=1 and floor_pos=i SHALL produce neither a lamp nor a pulse.
REQ-020 req_lamp[i] SHALL clear at the edge where door_open=1 and floor_pos=i are sampled; clear SHALL win over a set in the same cycle.
REQ-021 A floor_pos value of FLOORS or greater SHALL clear nothing.
REQ-022 Simultaneous qualifying edges on several floors SHALL pulse all of their floor_req bits in the same cycle.
REQ-023 floor_req and req_lamp SHALL be registered outputs with no combinational path from any input.
REQ-024 A stable 1->0 transition (button release) SHALL have no effect on the outputs.

Reset
REQ-025 While reset=1 at a clock edge, the synchronizers, stable bits, debounce counters, re-issue counter, floor_req and req_lamp SHALL all be cleared to 0.
REQ-026 Reset asserted mid-debounce SHALL discard progress; a button held through reset release SHALL produce its floor_req pulse 2+DEB_CYCLES+1 edges after the first edge with reset=0.

Configuration
REQ-027 With CALL_REISSUE_EN defined, a re-issue counter SHALL run while any lamp is set and reset to 0 while none is set.
REQ-028 With CALL_REISSUE_EN defined, at count REISSUE_CYCLES-1 the block SHALL pulse floor_req with the mask of lamps not being cleared that cycle for one cycle, OR-combined with any REQ-017 pulse, and the counter SHALL restart at 0.
REQ-029 Without CALL_REISSUE_EN, no counter SHALL exist and floor_req SHALL pulse only per REQ-017.

Verification
REQ-030 The bench SHALL hold btn_raw=5'b01000 from reset release and check floor_req=5'b01000 for one cycle at edge 7 and req_lamp[3]=1 from edge 7.
REQ-031 The bench SHALL apply a 3-cycle high glitch on btn_raw[1] and check that floor_req and req_lamp stay 0.
REQ-032 The bench SHALL press floor 4 three times, with 10 cycles high and 10 low each, and check exactly one floor_req[4] pulse.
REQ-033 The bench SHALL drive floor_pos=3 with door_open=1 for one cycle while lamp[3]=1, and check req_lamp[3]=0 at the next edge.
REQ-034 The bench SHALL press btn_raw=5'b10010 together and check floor_req=5'b10010 in the same single cycle.
REQ-035 With CALL_REISSUE_EN defined, the bench SHALL keep lamp[2] set and check floor_req=5'b00100 pulses every 16 cycles, stopping once the lamp clears.
